// File: rtl/ls_buffer.sv
// In-order load/store buffer: ops leave from the head one at a time through a
// single-outstanding memory port; results and store announcements go to the CDB.
module ls_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic        issue_valid,
    input  logic        issue_store,
    input  logic [2:0]  issue_funct3,
    input  logic [31:0] issue_tag,
    input  logic [31:0] issue_addr,
    input  logic [31:0] issue_data,
    output logic        full,
    input  logic        commit_valid,
    input  logic [31:0] commit_tag,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    output logic        ls_ready,
    output logic [31:0] ls_tag,
    output logic [31:0] ls_result
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {IDLE, MEM} state_t;

    state_t         state_reg;
    logic [AW-1:0]  head_reg, tail_reg, head_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           full_reg;
    logic           discard_reg;
    logic           cur_store_reg;
    logic [2:0]     cur_funct3_reg;
    logic [31:0]    cur_tag_reg;
    logic           mem_req_reg, mem_we_reg;
    logic [31:0]    mem_addr_reg, mem_wdata_reg;
    logic [1:0]     mem_size_reg;
    logic           ls_ready_reg;
    logic [31:0]    ls_tag_reg, ls_result_reg;

    logic           valid_reg     [DEPTH];
    logic           announced_reg [DEPTH];
    logic           committed_reg [DEPTH];
    logic           store_mem     [DEPTH];
    logic [2:0]     funct3_mem    [DEPTH];
    logic [31:0]    tag_mem       [DEPTH];
    logic [31:0]    addr_mem      [DEPTH];
    logic [31:0]    data_mem      [DEPTH];

    logic           h_valid, h_store, h_announced, h_committed;
    logic [2:0]     h_funct3;
    logic [31:0]    h_tag, h_addr, h_data;
    logic           push_en, pop_en, start_en, announce_en, commit_en, keep_en;

    function automatic logic [1:0] size_of(input logic [1:0] f);
        case (f)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'b0, d[7:0]};
            3'b101:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign h_valid     = valid_reg[head_reg];
    assign h_store     = store_mem[head_reg];
    assign h_announced = announced_reg[head_reg];
    assign h_committed = committed_reg[head_reg];
    assign h_funct3    = funct3_mem[head_reg];
    assign h_tag       = tag_mem[head_reg];
    assign h_addr      = addr_mem[head_reg];
    assign h_data      = data_mem[head_reg];

    // A discarded load has already lost its slot, so its completion must not pop.
    assign push_en     = issue_valid && !full_reg && !flush_in;
    assign pop_en      = (state_reg == MEM) && mem_done && !discard_reg;
    assign start_en    = (state_reg == IDLE) && !flush_in && h_valid && (!h_store || h_committed);
    assign announce_en = (state_reg == IDLE) && !flush_in && h_valid && h_store && !h_announced;
    assign commit_en   = !flush_in && h_valid && h_store && h_announced && !h_committed
                         && commit_valid && (commit_tag == h_tag);
    assign keep_en     = flush_in && h_valid && h_store && h_committed && !pop_en;
    assign head_next   = pop_en ? head_reg + AW'(1) : head_reg;
    assign count_next  = count_reg + CW'(push_en) - CW'(pop_en);

    always_ff @(posedge clk_in) begin
        if (push_en) begin
            store_mem[tail_reg]  <= issue_store;
            funct3_mem[tail_reg] <= issue_funct3;
            tag_mem[tail_reg]    <= issue_tag;
            addr_mem[tail_reg]   <= issue_addr;
            data_mem[tail_reg]   <= issue_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    valid_reg[gi]     <= 1'b0;
                    announced_reg[gi] <= 1'b0;
                    committed_reg[gi] <= 1'b0;
                end else if (flush_in) begin
                    if (!(keep_en && head_reg == AW'(gi))) begin
                        valid_reg[gi]     <= 1'b0;
                        announced_reg[gi] <= 1'b0;
                        committed_reg[gi] <= 1'b0;
                    end
                end else if (push_en && tail_reg == AW'(gi)) begin
                    valid_reg[gi]     <= 1'b1;
                    announced_reg[gi] <= 1'b0;
                    committed_reg[gi] <= 1'b0;
                end else if (pop_en && head_reg == AW'(gi)) begin
                    valid_reg[gi]     <= 1'b0;
                    announced_reg[gi] <= 1'b0;
                    committed_reg[gi] <= 1'b0;
                end else if (head_reg == AW'(gi)) begin
                    if (announce_en) announced_reg[gi] <= 1'b1;
                    if (commit_en)   committed_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= IDLE;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            discard_reg    <= 1'b0;
            cur_store_reg  <= 1'b0;
            cur_funct3_reg <= 3'b0;
            cur_tag_reg    <= 32'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 32'b0;
            mem_wdata_reg  <= 32'b0;
            mem_size_reg   <= 2'b0;
            ls_ready_reg   <= 1'b0;
            ls_tag_reg     <= 32'b0;
            ls_result_reg  <= 32'b0;
        end else begin
            ls_ready_reg <= 1'b0;
            head_reg     <= head_next;
            if (flush_in) begin
                tail_reg  <= keep_en ? head_reg + AW'(1) : head_next;
                count_reg <= keep_en ? CW'(1) : '0;
                full_reg  <= 1'b0;
            end else begin
                if (push_en) tail_reg <= tail_reg + AW'(1);
                count_reg <= count_next;
                full_reg  <= (count_next == DEPTH_C);
            end
            case (state_reg)
                IDLE: begin
                    if (start_en) begin
                        mem_req_reg    <= 1'b1;
                        mem_we_reg     <= h_store;
                        mem_addr_reg   <= h_addr;
                        mem_wdata_reg  <= h_store ? h_data : 32'b0;
                        mem_size_reg   <= size_of(h_funct3[1:0]);
                        cur_store_reg  <= h_store;
                        cur_funct3_reg <= h_funct3;
                        cur_tag_reg    <= h_tag;
                        state_reg      <= MEM;
                    end else if (announce_en) begin
                        ls_ready_reg  <= 1'b1;
                        ls_tag_reg    <= h_tag;
                        ls_result_reg <= 32'b0;
                    end
                end
                MEM: begin
                    if (mem_done) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        discard_reg <= 1'b0;
                        state_reg   <= IDLE;
                        if (!cur_store_reg && !discard_reg && !flush_in) begin
                            ls_ready_reg  <= 1'b1;
                            ls_tag_reg    <= cur_tag_reg;
                            ls_result_reg <= load_ext(cur_funct3_reg, mem_rdata);
                        end
                    end else if (flush_in && !cur_store_reg) begin
                        discard_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign full      = full_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_size  = mem_size_reg;
    assign ls_ready  = ls_ready_reg;
    assign ls_tag    = ls_tag_reg;
    assign ls_result = ls_result_reg;
endmodule

// File: tb/tb_ls_buffer.sv
// Scoreboard bench for ls_buffer: a memory responder and a CDB monitor pop
// expectations pushed by the directed stimulus.
module tb_ls_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_in = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_store = 1'b0;
    logic [2:0]  issue_funct3 = 3'b0;
    logic [31:0] issue_tag = 32'b0;
    logic [31:0] issue_addr = 32'b0;
    logic [31:0] issue_data = 32'b0;
    logic        full;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_tag = 32'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        ls_ready;
    logic [31:0] ls_tag, ls_result;

    typedef struct {
        logic [31:0] tag;
        logic [31:0] result;
    } cdb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] rdata;
        int          lat;
    } mreq_t;

    cdb_t  cdb_q[$];
    mreq_t mem_q[$];
    cdb_t  mon_e;
    int    n_vec = 0;
    int    n_err = 0;
    bit    resp_busy = 1'b0;

    ls_buffer #(.DEPTH(8)) dut (
        .clk_in(clk), .rst_in(rst), .flush_in(flush_in),
        .issue_valid(issue_valid), .issue_store(issue_store), .issue_funct3(issue_funct3),
        .issue_tag(issue_tag), .issue_addr(issue_addr), .issue_data(issue_data),
        .full(full), .commit_valid(commit_valid), .commit_tag(commit_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ls_ready(ls_ready), .ls_tag(ls_tag), .ls_result(ls_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ls_ready) begin
            if (cdb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL cdb_unexpected: got tag=%h result=%h, expected no broadcast", ls_tag, ls_result);
            end else begin
                mon_e = cdb_q.pop_front();
                $display("cdb  tag=%h result=%h", ls_tag, ls_result);
                check("ls_tag", ls_tag, mon_e.tag);
                check("ls_result", ls_result, mon_e.result);
            end
        end
    end

    initial begin : responder
        mreq_t e;
        bit    aborted;
        mem_done  = 1'b0;
        mem_rdata = 32'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_req && !rst) begin
                resp_busy = 1'b1;
                if (mem_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_unexpected: got we=%0d addr=%h, expected no request", mem_we, mem_addr);
                    e.we = mem_we; e.addr = mem_addr; e.wdata = mem_wdata;
                    e.size = mem_size; e.rdata = 32'b0; e.lat = 1;
                end else begin
                    e = mem_q.pop_front();
                    $display("mem  we=%0d addr=%h wdata=%h size=%0d", mem_we, mem_addr, mem_wdata, mem_size);
                    check("mem_we", mem_we, e.we);
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_size", mem_size, e.size);
                    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                end
                aborted = 1'b0;
                for (int k = 0; k < e.lat; k++) begin
                    @(posedge clk); #1;
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("mem_hold", {mem_req, mem_we, mem_addr, mem_size}, {1'b1, e.we, e.addr, e.size});
                    if (e.we) check("wdata_hold", mem_wdata, e.wdata);
                end
                if (!aborted) begin
                    mem_rdata = e.rdata;
                    mem_done  = 1'b1;
                    @(posedge clk); #1;
                    mem_done  = 1'b0;
                    mem_rdata = 32'b0;
                    if (!rst) check("mem_req_drop", mem_req, 1'b0);
                end
                resp_busy = 1'b0;
            end
        end
    end

    task automatic do_issue(input logic st, input logic [2:0] f3, input logic [31:0] tag,
                            input logic [31:0] addr, input logic [31:0] data);
        issue_valid = 1'b1; issue_store = st; issue_funct3 = f3;
        issue_tag = tag; issue_addr = addr; issue_data = data;
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    task automatic load_vec(input logic [2:0] f3, input logic [31:0] tag, input logic [31:0] addr,
                            input logic [1:0] size, input logic [31:0] rdata, input int lat,
                            input logic [31:0] exp_result);
        mreq_t m;
        cdb_t  c;
        m.we = 1'b0; m.addr = addr; m.wdata = 32'b0; m.size = size; m.rdata = rdata; m.lat = lat;
        c.tag = tag; c.result = exp_result;
        mem_q.push_back(m);
        cdb_q.push_back(c);
        do_issue(1'b0, f3, tag, addr, 32'b0);
    endtask

    task automatic push_store_mem(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [1:0] size, input int lat);
        mreq_t m;
        m.we = 1'b1; m.addr = addr; m.wdata = data; m.size = size; m.rdata = 32'b0; m.lat = lat;
        mem_q.push_back(m);
    endtask

    task automatic push_cdb(input logic [31:0] tag, input logic [31:0] result);
        cdb_t c;
        c.tag = tag; c.result = result;
        cdb_q.push_back(c);
    endtask

    task automatic do_commit(input logic [31:0] tag);
        commit_valid = 1'b1; commit_tag = tag;
        @(posedge clk); #1;
        commit_valid = 1'b0;
    endtask

    task automatic do_flush(input logic with_issue);
        flush_in = 1'b1;
        if (with_issue) begin
            issue_valid = 1'b1; issue_store = 1'b0; issue_funct3 = 3'b010;
            issue_tag = 32'd99; issue_addr = 32'h3FC;
        end
        @(posedge clk); #1;
        flush_in = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (cdb_q.size() == 0 && mem_q.size() == 0 && !mem_req && !resp_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic wait_cdb_empty(input string name, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (cdb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic wait_mem_req(input string name, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_full"}, full, 1'b0);
        check({name, "_mem_req"}, mem_req, 1'b0);
        check({name, "_mem_we"}, mem_we, 1'b0);
        check({name, "_mem_addr"}, mem_addr, 32'b0);
        check({name, "_mem_wdata"}, mem_wdata, 32'b0);
        check({name, "_mem_size"}, mem_size, 2'b0);
        check({name, "_ls_ready"}, ls_ready, 1'b0);
        check({name, "_ls_tag"}, ls_tag, 32'b0);
        check({name, "_ls_result"}, ls_result, 32'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check_all_zero("reset");
        @(posedge clk); #1;

        // Loads and extension rules
        load_vec(3'b000, 32'd1, 32'h10, 2'd0, 32'h000000F0, 2, 32'hFFFFFFF0);
        wait_idle("lb_drain", 40);
        load_vec(3'b101, 32'd5, 32'h20, 2'd1, 32'h0000ABCD, 1, 32'h0000ABCD);
        load_vec(3'b010, 32'd6, 32'h24, 2'd2, 32'h12345678, 3, 32'h12345678);
        load_vec(3'b001, 32'd8, 32'h26, 2'd1, 32'h00008001, 0, 32'hFFFF8001);
        load_vec(3'b100, 32'd9, 32'h27, 2'd0, 32'h000000F0, 1, 32'h000000F0);
        load_vec(3'b011, 32'd11, 32'h28, 2'd2, 32'hCAFEBABE, 1, 32'hCAFEBABE);
        wait_idle("loads_drain", 100);

        // Store: announce, wait for matching commit, then write
        push_cdb(32'd7, 32'd0);
        do_issue(1'b1, 3'b010, 32'd7, 32'h40, 32'hDEADBEEF);
        wait_cdb_empty("sw_announce", 10);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("sw_wait_noreq", mem_req, 1'b0);
        end
        do_commit(32'd3);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("sw_wrongtag_noreq", mem_req, 1'b0);
        end
        push_store_mem(32'h40, 32'hDEADBEEF, 2'd2, 3);
        do_commit(32'd7);
        wait_idle("sw_drain", 40);

        // Fill to full, dropped ninth issue, wrap-around order
        for (int i = 0; i < 8; i++)
            load_vec(3'b010, 32'd50 + i, 32'h100 + 4 * i, 2'd2, 32'hA0000000 + i,
                     (i == 0) ? 20 : 1, 32'hA0000000 + i);
        check("full_at_8", full, 1'b1);
        do_issue(1'b0, 3'b010, 32'd99, 32'h1FC, 32'b0);
        check("full_after_drop", full, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (!full) begin
                ok = 1'b1;
                break;
            end
        end
        check("full_clears_after_pop", ok, 1'b1);
        load_vec(3'b010, 32'd58, 32'h120, 2'd2, 32'hA0000008, 1, 32'hA0000008);
        wait_idle("fill_drain", 200);

        // Flush with a load in MEM plus three queued and an issue in the flush cycle
        begin
            mreq_t m;
            m.we = 1'b0; m.addr = 32'h300; m.wdata = 32'b0; m.size = 2'd2;
            m.rdata = 32'h77777777; m.lat = 6;
            mem_q.push_back(m);
        end
        do_issue(1'b0, 3'b010, 32'd20, 32'h300, 32'b0);
        do_issue(1'b0, 3'b010, 32'd21, 32'h304, 32'b0);
        do_issue(1'b0, 3'b010, 32'd22, 32'h308, 32'b0);
        do_issue(1'b0, 3'b010, 32'd23, 32'h30C, 32'b0);
        do_flush(1'b1);
        check("flush_full", full, 1'b0);
        load_vec(3'b000, 32'd24, 32'h310, 2'd0, 32'h0000007F, 1, 32'h0000007F);
        wait_idle("flush_load_drain", 60);

        // Flush while a committed store is writing
        push_cdb(32'd30, 32'd0);
        do_issue(1'b1, 3'b010, 32'd30, 32'h400, 32'h11223344);
        wait_cdb_empty("sw30_announce", 10);
        do_issue(1'b0, 3'b010, 32'd31, 32'h404, 32'b0);
        push_store_mem(32'h400, 32'h11223344, 2'd2, 5);
        do_commit(32'd30);
        wait_mem_req("sw30_req", 10);
        do_flush(1'b0);
        wait_idle("sw30_flush_drain", 40);
        load_vec(3'b010, 32'd32, 32'h408, 2'd2, 32'h55AA55AA, 1, 32'h55AA55AA);
        wait_idle("after_flush_drain", 40);

        // Reset in the middle of a memory access
        begin
            mreq_t m;
            m.we = 1'b0; m.addr = 32'h200; m.wdata = 32'b0; m.size = 2'd2;
            m.rdata = 32'h0; m.lat = 50;
            mem_q.push_back(m);
        end
        do_issue(1'b0, 3'b010, 32'd40, 32'h200, 32'b0);
        wait_mem_req("rst_mem_req", 10);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_all_zero("midrst");
        @(posedge clk); #1;
        load_vec(3'b001, 32'd41, 32'h204, 2'd1, 32'h00007FFF, 1, 32'h00007FFF);
        wait_idle("post_rst_drain", 40);

        check("cdb_q_left", cdb_q.size(), 0);
        check("mem_q_left", mem_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
